vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between a stalled Z80 CPU and a video fetcher
// Video wins by default; the CPU is forced in after STARVE_MAX video grants while it waits.
module vram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_sel,
  input  logic              cpu_wrn,
  input  logic              cpu_rdn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              vram_busy,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ovf,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [2:0]        starve_q, starve_d;
  logic              ovf_q, ovf_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_rd_ack_q, cpu_rd_ack_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

  logic capture;
  logic force_cpu;
  logic gnt_cpu;
  logic gnt_hold;
  logic gnt_req;
  logic gnt_vid;

  // cpu_done blocks re-capture of a strobe that has already been serviced.
  assign capture   = !rst_n && cpu_sel && (!cpu_wrn || !cpu_rdn) && !cpu_pend_q && !cpu_done_q;
  assign force_cpu = !rst_n && cpu_pend_q && (starve_q == STARVE_LIM);
  assign gnt_cpu   = force_cpu || (!rst_n && cpu_pend_q && !hold_full_q && !vid_req);
  assign gnt_hold  = !rst_n && !force_cpu && hold_full_q;
  assign gnt_req   = !rst_n && !force_cpu && !hold_full_q && vid_req;
  assign gnt_vid   = gnt_hold || gnt_req;

  assign vram_busy = cpu_pend_q || capture;

  always_comb begin
    mem_en    = gnt_cpu || gnt_vid;
    mem_we    = gnt_cpu && cpu_we_q;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_addr = cpu_addr_q;
      if (cpu_we_q) mem_wdata = cpu_wdata_q;
    end else if (gnt_hold) begin
      mem_addr = hold_addr_q;
    end else if (gnt_req) begin
      mem_addr = vid_addr;
    end
  end

  always_comb begin
    cpu_pend_d  = cpu_pend_q;
    cpu_done_d  = cpu_done_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    if (capture) begin
      cpu_pend_d  = 1'b1;
      cpu_we_d    = !cpu_wrn;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
    end
    if (gnt_cpu) cpu_pend_d = 1'b0;
    if (cpu_wrn && cpu_rdn) cpu_done_d = 1'b0;
    if (gnt_cpu) cpu_done_d = 1'b1;
  end

  // A request that loses arbitration parks in the hold slot; if the slot is
  // occupied and not draining this cycle, the request is lost.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_addr_d = hold_addr_q;
    ovf_d       = ovf_q;
    if (gnt_hold) hold_full_d = 1'b0;
    if (vid_req && !gnt_req) begin
      if (!hold_full_q || gnt_hold) begin
        hold_full_d = 1'b1;
        hold_addr_d = vid_addr;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!cpu_pend_q || gnt_cpu) begin
      starve_d = 3'd0;
    end else if (gnt_vid && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // RAM data arrives the cycle after the grant, so it is forwarded directly
  // in that cycle and captured for holding afterwards.
  always_comb begin
    cpu_ack_d    = gnt_cpu;
    cpu_rd_ack_d = gnt_cpu && !cpu_we_q;
    vid_valid_d  = gnt_vid;
    cpu_rdata_d  = cpu_rd_ack_q ? mem_rdata : cpu_rdata_q;
    vid_rdata_d  = vid_valid_q ? mem_rdata : vid_rdata_q;
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rd_ack_q ? mem_rdata : cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_rdata = vid_valid_q ? mem_rdata : vid_rdata_q;
  assign vid_ovf   = ovf_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cpu_pend_q   <= 1'b0;
      cpu_done_q   <= 1'b0;
      cpu_we_q     <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_wdata_q  <= '0;
      hold_full_q  <= 1'b0;
      hold_addr_q  <= '0;
      starve_q     <= 3'd0;
      ovf_q        <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rd_ack_q <= 1'b0;
      vid_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else begin
      cpu_pend_q   <= cpu_pend_d;
      cpu_done_q   <= cpu_done_d;
      cpu_we_q     <= cpu_we_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_wdata_q  <= cpu_wdata_d;
      hold_full_q  <= hold_full_d;
      hold_addr_q  <= hold_addr_d;
      starve_q     <= starve_d;
      ovf_q        <= ovf_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rd_ack_q <= cpu_rd_ack_d;
      vid_valid_q  <= vid_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter
// Stimulus pushes expected RAM accesses, CPU acks and video data; a negedge monitor pops and compares.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_sel, cpu_wrn, cpu_rdn;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_ack, vram_busy;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic       vid_valid;
  logic [7:0] vid_rdata;
  logic       vid_ovf;
  logic       mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  vram_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_sel(cpu_sel), .cpu_wrn(cpu_wrn), .cpu_rdn(cpu_rdn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .vram_busy(vram_busy),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
    .vid_rdata(vid_rdata), .vid_ovf(vid_ovf),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [9:0] addr; logic [7:0] data; } mem_t;
  typedef struct { int cyc; logic rd; logic [7:0] data; } cpu_t;
  typedef struct { int cyc; logic [7:0] data; } vid_t;
  mem_t exp_mem[$];
  cpu_t exp_cpu[$];
  vid_t exp_vid[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ram_init(int a);
    if (a == 'h123) return 8'hA5;
    return 8'(a) ^ 8'h5A;
  endfunction

  // Single-port synchronous RAM, read-before-write, loaded during the first reset cycle.
  logic [7:0] ram [0:1023];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ram_init(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_mem(int c, logic we, logic [9:0] a, logic [7:0] d);
    mem_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d;
    exp_mem.push_back(e);
  endfunction

  function automatic void push_cpu(int c, logic rd, logic [7:0] d);
    cpu_t e;
    e.cyc = c; e.rd = rd; e.data = d;
    exp_cpu.push_back(e);
  endfunction

  function automatic void push_vid(int c, logic [7:0] d);
    vid_t e;
    e.cyc = c; e.data = d;
    exp_vid.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mem_en) begin
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: actual access addr 0x%0h we %0b required none (cycle %0d)", mem_addr, mem_we, cyc);
      end else begin
        mem_t e;
        e = exp_mem.pop_front();
        chk("mem_cycle", cyc, e.cyc);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (cpu_ack) begin
      checks++;
      if (exp_cpu.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: actual cpu_ack 1 required 0 (cycle %0d)", cyc);
      end else begin
        cpu_t e;
        e = exp_cpu.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end
    if (vid_valid) begin
      checks++;
      if (exp_vid.size() == 0) begin
        errors++;
        $display("FAIL vid_unexpected: actual vid_valid 1 required 0 (cycle %0d)", cyc);
      end else begin
        vid_t e;
        e = exp_vid.pop_front();
        chk("vid_cycle", cyc, e.cyc);
        chk("vid_rdata", 32'(vid_rdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [9:0] a, input logic [7:0] d);
    cpu_sel   = 1'b1;
    cpu_wrn   = !we;
    cpu_rdn   = we;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic cpu_release();
    cpu_sel = 1'b0;
    cpu_wrn = 1'b1;
    cpu_rdn = 1'b1;
  endtask

  // Idle-bus access: capture at b, grant at b+1, ack at b+2.
  task automatic idle_access(input logic we, input logic [9:0] a, input logic [7:0] d, input logic [7:0] rexp);
    int b;
    b = cyc;
    push_mem(b + 1, we, a, we ? d : 8'h00);
    push_cpu(b + 2, !we, rexp);
    cpu_drive(we, a, d);
    @(negedge clk);
    chk("busy_capture", 32'(vram_busy), 1);
    tick();
    tick();
    @(negedge clk);
    chk("busy_after_ack", 32'(vram_busy), 0);
    tick();
    cpu_release();
    tick();
    tick();
  endtask

  initial begin
    int b;
    rst_n = 1'b1;
    cpu_release();
    cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_vid_rdata", 32'(vid_rdata), 0);
    chk("rst_vid_ovf", 32'(vid_ovf), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    tick();
    rst_n = 1'b0;
    tick();

    idle_access(1'b1, 10'h040, 8'h05, 8'h00);
    idle_access(1'b0, 10'h123, 8'h00, 8'hA5);
    @(negedge clk);
    chk("rdata_hold", 32'(cpu_rdata), 32'hA5);
    tick();
    idle_access(1'b0, 10'h040, 8'h00, 8'h05);

    // Starvation then overflow: video every cycle with two CPU writes.
    b = cyc;
    for (int k = 0; k < 5; k++) begin
      push_mem(b + k, 1'b0, 10'(32'h100 + k), 8'h00);
      push_vid(b + k + 1, ram_init(32'h100 + k));
    end
    push_mem(b + 5, 1'b1, 10'h210, 8'h11);
    push_cpu(b + 6, 1'b0, 8'h00);
    for (int k = 6; k < 13; k++) begin
      push_mem(b + k, 1'b0, 10'(32'h100 + k - 1), 8'h00);
      push_vid(b + k + 1, ram_init(32'h100 + k - 1));
    end
    push_mem(b + 13, 1'b1, 10'h211, 8'h22);
    push_cpu(b + 14, 1'b0, 8'h00);
    push_mem(b + 14, 1'b0, 10'h10C, 8'h00);
    push_vid(b + 15, ram_init(32'h10C));
    for (int k = 0; k < 18; k++) begin
      vid_req  = (k < 14);
      vid_addr = 10'(32'h100 + k);
      if (k == 0) cpu_drive(1'b1, 10'h210, 8'h11);
      if (k == 7) cpu_release();
      if (k == 8) cpu_drive(1'b1, 10'h211, 8'h22);
      if (k == 15) cpu_release();
      @(negedge clk);
      if (k == 12) chk("ovf_after_starve", 32'(vid_ovf), 0);
      if (k == 14) chk("ovf_set", 32'(vid_ovf), 1);
      tick();
    end
    vid_req = 1'b0;

    // One strobe, one access: hold the write strobe long after the ack.
    b = cyc;
    push_mem(b + 1, 1'b1, 10'h0A0, 8'h3C);
    push_cpu(b + 2, 1'b0, 8'h00);
    push_mem(b + 15, 1'b1, 10'h0A0, 8'h4D);
    push_cpu(b + 16, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      if (k == 0) cpu_drive(1'b1, 10'h0A0, 8'h3C);
      if (k == 13) cpu_release();
      if (k == 14) cpu_drive(1'b1, 10'h0A0, 8'h4D);
      if (k == 17) cpu_release();
      @(negedge clk);
      if (k == 6 || k == 12) chk("busy_held_strobe", 32'(vram_busy), 0);
      tick();
    end
    idle_access(1'b0, 10'h0A0, 8'h00, 8'h4D);
    @(negedge clk);
    chk("ovf_sticky", 32'(vid_ovf), 1);
    tick();

    // Reset one cycle after a read capture; strobe stays low throughout.
    cpu_drive(1'b0, 10'h123, 8'h00);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("midrst_vid_ovf", 32'(vid_ovf), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    tick();
    tick();
    rst_n = 1'b0;
    b = cyc;
    push_mem(b + 1, 1'b0, 10'h123, 8'h00);
    push_cpu(b + 2, 1'b1, 8'hA5);
    tick();
    tick();
    tick();
    cpu_release();
    repeat (4) tick();
    @(negedge clk);
    chk("ovf_after_reset", 32'(vid_ovf), 0);

    chk("left_mem", 32'(exp_mem.size()), 0);
    chk("left_cpu", 32'(exp_cpu.size()), 0);
    chk("left_vid", 32'(exp_vid.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
